// File: rtl/fp_addsub_norm_round.sv
// Binary32 add/sub back end: normalizes the aligned significand sum, rounds to
// nearest-even, saturates on overflow, flushes on underflow and packs the result.
module fp_addsub_norm_round #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_sign,
    input  logic [EXP_W-1:0]      in_exp,
    input  logic [FRAC_W+1:0]     in_sig,
    input  logic [2:0]            in_grs,
    input  logic [4:0]            in_shiftleft,
    input  logic                  in_zero,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [EXP_W+FRAC_W:0] out_result,
    output logic                  out_overflow,
    output logic                  out_underflow
);

    localparam int SIG_W = FRAC_W + 1;
    localparam int X_W   = SIG_W + 3;
    localparam int E_W   = EXP_W + 2;
    localparam int RES_W = EXP_W + FRAC_W + 1;

    localparam logic signed [E_W-1:0] E_ZERO = '0;
    localparam logic signed [E_W-1:0] E_ONE  = E_W'(1);
    localparam logic signed [E_W-1:0] E_MAX  = E_W'((1 << EXP_W) - 1);

    function automatic logic [SIG_W:0] round_rne(
        input logic [SIG_W-1:0] m,
        input logic             g,
        input logic             r,
        input logic             st
    );
        logic up;
        up = g & (r | st | m[0]);
        return {1'b0, m} + {{SIG_W{1'b0}}, up};
    endfunction

    // Returns {overflow, packed result}; saturates to infinity at the all-ones exponent.
    function automatic logic [RES_W:0] pack_sat(
        input logic                  sign,
        input logic signed [E_W-1:0] e,
        input logic [FRAC_W-1:0]     frac
    );
        if (e >= E_MAX)
            return {1'b1, sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        return {1'b0, sign, e[EXP_W-1:0], frac};
    endfunction

    logic                  vld_p1, vld_p2;
    logic                  s1_adv;

    logic                  carry_p0;
    logic [X_W-1:0]        x_p0;
    logic [SIG_W-1:0]      m_p0;
    logic                  g_p0, r_p0, st_p0, uf_p0;
    logic signed [E_W-1:0] exp_ext_p0, shl_ext_p0, e_p0;

    logic                  sign_p1, zero_p1, uf_p1;
    logic [SIG_W-1:0]      m_p1;
    logic                  g_p1, r_p1, st_p1;
    logic signed [E_W-1:0] e_p1;

    logic [SIG_W:0]        mr_p1;
    logic [FRAC_W-1:0]     frac_p1;
    logic signed [E_W-1:0] er_p1;
    logic [RES_W:0]        pk_p1;
    logic [RES_W-1:0]      res_p1;
    logic                  ovf_p1, ufo_p1;

    assign s1_adv    = ~vld_p2 | out_ready;
    assign in_ready  = rst_n & (~vld_p1 | s1_adv);
    assign out_valid = vld_p2;

    // ---- stage 1: normalize (carry shifts right by one, otherwise LOD left shift)
    assign carry_p0   = in_sig[SIG_W];
    assign exp_ext_p0 = $signed({{(E_W-EXP_W){1'b0}}, in_exp});
    assign shl_ext_p0 = $signed({{(E_W-5){1'b0}}, in_shiftleft});

    always_comb begin
        x_p0 = {in_sig[SIG_W-1:0], in_grs} << in_shiftleft;
        if (carry_p0) begin
            m_p0  = in_sig[SIG_W:1];
            g_p0  = in_sig[0];
            r_p0  = in_grs[2];
            st_p0 = in_grs[1] | in_grs[0];
            e_p0  = exp_ext_p0 + E_ONE;
        end else begin
            m_p0  = x_p0[X_W-1:3];
            g_p0  = x_p0[2];
            r_p0  = x_p0[1];
            st_p0 = x_p0[0];
            e_p0  = exp_ext_p0 - shl_ext_p0;
        end
        uf_p0 = ~in_zero & ~carry_p0 & (e_p0 <= E_ZERO);
    end

    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            sign_p1 <= in_sign;
            zero_p1 <= in_zero;
            uf_p1   <= uf_p0;
            m_p1    <= m_p0;
            g_p1    <= g_p0;
            r_p1    <= r_p0;
            st_p1   <= st_p0;
            e_p1    <= e_p0;
        end
    end

    // ---- stage 2: round to nearest-even, renormalize on carry-out, pack
    always_comb begin
        mr_p1 = round_rne(m_p1, g_p1, r_p1, st_p1);
        if (mr_p1[SIG_W]) begin
            frac_p1 = mr_p1[SIG_W-1:1];
            er_p1   = e_p1 + E_ONE;
        end else begin
            frac_p1 = mr_p1[FRAC_W-1:0];
            er_p1   = e_p1;
        end
        pk_p1  = pack_sat(sign_p1, er_p1, frac_p1);
        res_p1 = pk_p1[RES_W-1:0];
        ovf_p1 = pk_p1[RES_W];
        ufo_p1 = 1'b0;
        if (zero_p1 || uf_p1) begin
            res_p1 = {sign_p1, {(RES_W-1){1'b0}}};
            ovf_p1 = 1'b0;
            ufo_p1 = uf_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1        <= 1'b0;
            vld_p2        <= 1'b0;
            out_result    <= '0;
            out_overflow  <= 1'b0;
            out_underflow <= 1'b0;
        end else begin
            if (in_ready)
                vld_p1 <= in_valid;
            if (s1_adv) begin
                vld_p2 <= vld_p1;
                if (vld_p1) begin
                    out_result    <= res_p1;
                    out_overflow  <= ovf_p1;
                    out_underflow <= ufo_p1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fp_addsub_norm_round.sv
// Directed-vector bench for fp_addsub_norm_round: reset, normalize, rounding,
// overflow/underflow boundaries, backpressure and mid-flight reset.
module tb_fp_addsub_norm_round;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [24:0] sig;
        logic [2:0]  grs;
        logic [4:0]  sl;
        logic        zero;
        logic [31:0] want;
        logic        ovf;
        logic        uf;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [24:0] in_sig;
    logic [2:0]  in_grs;
    logic [4:0]  in_shiftleft;
    logic        in_zero;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_overflow;
    logic        out_underflow;

    int checks = 0;
    int errors = 0;

    fp_addsub_norm_round dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_sign       (in_sign),
        .in_exp        (in_exp),
        .in_sig        (in_sig),
        .in_grs        (in_grs),
        .in_shiftleft  (in_shiftleft),
        .in_zero       (in_zero),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_overflow  (out_overflow),
        .out_underflow (out_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic drive(input vec_t v);
        in_sign      = v.sign;
        in_exp       = v.exp;
        in_sig       = v.sig;
        in_grs       = v.grs;
        in_shiftleft = v.sl;
        in_zero      = v.zero;
    endtask

    // One transaction through an otherwise idle pipeline; lat counts edges from acceptance.
    task automatic run_vec(input vec_t v, output logic [31:0] res, output logic ovf,
                           output logic uf, output int lat);
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        drive(v);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        res = out_result;
        ovf = out_overflow;
        uf  = out_underflow;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        drive('0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_result !== 32'h0 || out_overflow !== 1'b0 ||
            out_underflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b r=%h o=%b u=%b want all 0",
                     out_valid, out_result, out_overflow, out_underflow);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready got %b want 0", in_ready);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL release_in_ready got %b want 1", in_ready);
        end
    endtask

    task automatic test_basic();
        vec_t        tbl [5];
        logic [31:0] res;
        logic        ovf, uf;
        int          lat;
        tbl[0] = '{1'b0, 8'd127, 25'h1000000, 3'b000, 5'd0, 1'b0, 32'h40000000, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 8'd127, 25'h0400000, 3'b000, 5'd1, 1'b0, 32'h3F000000, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 8'd127, 25'h0000000, 3'b101, 5'd0, 1'b1, 32'h00000000, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 8'd127, 25'h1000000, 3'b000, 5'd0, 1'b0, 32'hC0000000, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 8'd50,  25'h0000000, 3'b111, 5'd0, 1'b1, 32'h80000000, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            run_vec(tbl[i], res, ovf, uf, lat);
            checks++;
            if (lat != 2) begin
                errors++;
                $display("FAIL basic%0d_latency got %0d want 2", i, lat);
            end
            checks++;
            if (res !== tbl[i].want || ovf !== tbl[i].ovf || uf !== tbl[i].uf) begin
                errors++;
                $display("FAIL basic%0d got %h o=%b u=%b want %h o=%b u=%b",
                         i, res, ovf, uf, tbl[i].want, tbl[i].ovf, tbl[i].uf);
            end
        end
    endtask

    task automatic test_rounding();
        vec_t        tbl [8];
        logic [31:0] res;
        logic        ovf, uf;
        int          lat;
        tbl[0] = '{1'b0, 8'd127, 25'h0800001, 3'b100, 5'd0, 1'b0, 32'h3F800002, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 8'd127, 25'h0800000, 3'b100, 5'd0, 1'b0, 32'h3F800000, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 8'd127, 25'h0FFFFFF, 3'b110, 5'd0, 1'b0, 32'h40000000, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 8'd127, 25'h0800000, 3'b101, 5'd0, 1'b0, 32'h3F800001, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 8'd127, 25'h0800000, 3'b011, 5'd0, 1'b0, 32'h3F800000, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 8'd127, 25'h1000001, 3'b100, 5'd0, 1'b0, 32'h40000001, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 8'd127, 25'h1000003, 3'b000, 5'd0, 1'b0, 32'h40000002, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 8'd127, 25'h0400000, 3'b100, 5'd1, 1'b0, 32'h3F000001, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            run_vec(tbl[i], res, ovf, uf, lat);
            checks++;
            if (res !== tbl[i].want || ovf !== tbl[i].ovf || uf !== tbl[i].uf) begin
                errors++;
                $display("FAIL round%0d got %h o=%b u=%b want %h o=%b u=%b",
                         i, res, ovf, uf, tbl[i].want, tbl[i].ovf, tbl[i].uf);
            end
        end
    endtask

    task automatic test_over_under();
        vec_t        tbl [7];
        logic [31:0] res;
        logic        ovf, uf;
        int          lat;
        tbl[0] = '{1'b0, 8'd254, 25'h1000000, 3'b000, 5'd0, 1'b0, 32'h7F800000, 1'b1, 1'b0};
        tbl[1] = '{1'b0, 8'd3,   25'h0040000, 3'b000, 5'd5, 1'b0, 32'h00000000, 1'b0, 1'b1};
        tbl[2] = '{1'b0, 8'd254, 25'h0FFFFFF, 3'b000, 5'd0, 1'b0, 32'h7F7FFFFF, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 8'd254, 25'h0FFFFFF, 3'b110, 5'd0, 1'b0, 32'h7F800000, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 8'd1,   25'h0800000, 3'b000, 5'd0, 1'b0, 32'h00800000, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 8'd1,   25'h0400000, 3'b000, 5'd1, 1'b0, 32'h80000000, 1'b0, 1'b1};
        tbl[6] = '{1'b0, 8'd253, 25'h1000000, 3'b000, 5'd0, 1'b0, 32'h7F000000, 1'b0, 1'b0};
        for (int i = 0; i < 7; i++) begin
            run_vec(tbl[i], res, ovf, uf, lat);
            checks++;
            if (res !== tbl[i].want || ovf !== tbl[i].ovf || uf !== tbl[i].uf) begin
                errors++;
                $display("FAIL ovuf%0d got %h o=%b u=%b want %h o=%b u=%b",
                         i, res, ovf, uf, tbl[i].want, tbl[i].ovf, tbl[i].uf);
            end
        end
    endtask

    task automatic test_back_to_back();
        vec_t        tbl [4];
        logic [31:0] got [$];
        logic [31:0] held;
        int          sent;
        int          cyc;
        sent = 0;
        cyc  = 0;
        held = '0;
        tbl[0] = '{1'b0, 8'd127, 25'h1000000, 3'b000, 5'd0, 1'b0, 32'h40000000, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 8'd127, 25'h0400000, 3'b000, 5'd1, 1'b0, 32'h3F000000, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 8'd127, 25'h0800001, 3'b100, 5'd0, 1'b0, 32'h3F800002, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 8'd127, 25'h1000000, 3'b000, 5'd0, 1'b0, 32'hC0000000, 1'b0, 1'b0};
        while (got.size() < 4 && cyc < 40) begin
            @(negedge clk);
            out_ready = (cyc >= 5);
            if (sent < 4) begin
                in_valid = 1'b1;
                drive(tbl[sent]);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (cyc >= 2 && cyc <= 4) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_in_ready cyc%0d got %b want 0", cyc, in_ready);
                end
            end
            if (cyc == 2)
                held = out_result;
            if (cyc == 3 || cyc == 4) begin
                checks++;
                if (out_valid !== 1'b1 || out_result !== held) begin
                    errors++;
                    $display("FAIL stall_hold cyc%0d got v=%b %h want v=1 %h",
                             cyc, out_valid, out_result, held);
                end
            end
            if (out_valid === 1'b1 && out_ready === 1'b1)
                got.push_back(out_result);
            if (in_valid === 1'b1 && in_ready === 1'b1)
                sent++;
            @(posedge clk);
            cyc++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (got.size() != 4) begin
            errors++;
            $display("FAIL b2b_count got %0d want 4", got.size());
        end
        for (int i = 0; i < 4; i++) begin
            if (i < got.size()) begin
                checks++;
                if (got[i] !== tbl[i].want) begin
                    errors++;
                    $display("FAIL b2b_order%0d got %h want %h", i, got[i], tbl[i].want);
                end
            end
        end
    endtask

    task automatic test_reset_midflight();
        vec_t tx, ty;
        int   stale;
        stale = 0;
        tx = '{1'b0, 8'd127, 25'h1000000, 3'b000, 5'd0, 1'b0, 32'h40000000, 1'b0, 1'b0};
        ty = '{1'b0, 8'd254, 25'h1000000, 3'b000, 5'd0, 1'b0, 32'h7F800000, 1'b1, 1'b0};
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        drive(tx);
        @(posedge clk);
        @(negedge clk);
        drive(ty);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_result !== 32'h40000000) begin
            errors++;
            $display("FAIL inflight_pre got v=%b %h want v=1 40000000", out_valid, out_result);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL midrst_in_ready got %b want 0", in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_result !== 32'h0 || out_overflow !== 1'b0 ||
            out_underflow !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL midrst_outputs got v=%b r=%h o=%b u=%b rdy=%b want all 0",
                     out_valid, out_result, out_overflow, out_underflow, in_ready);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_release got %b want 1", in_ready);
        end
        repeat (6) begin
            @(negedge clk);
            if (out_valid !== 1'b0)
                stale++;
        end
        checks++;
        if (stale != 0) begin
            errors++;
            $display("FAIL midrst_stale got %0d valid cycles want 0", stale);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_over_under();
        test_back_to_back();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
